wb_result_stage: RTL
====================

# wb_result_stage

Parametrised, registered successor to the processor's combinational result selector. It selects one of NUM_SRC writeback sources, formats load data (byte/half/word, sign/zero extension, byte-lane alignment), and holds the result in a one-entry pipeline register. The register sits between the execute/memory stages and the register-file write port and uses a valid/ready handshake. It also supports a synchronous flush and flags illegal selects and misaligned loads.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be ≥ 32.
- NUM_SRC, 4, number of result sources; must be ≥ 2.
- LOAD_SRC, 1, index of the source carrying raw memory read data; load formatting applies only to this source.
- SEL_W, $clog2(NUM_SRC), select width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- src_data  in  NUM_SRC*WIDTH  packed sources; source i occupies [i*WIDTH +: WIDTH].
- sel  in  SEL_W  source select.
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- addr_lo  in  2  low byte-address bits of the load.
- in_valid  in  1  upstream offers a result.
- in_ready  out  1  stage can accept a result this cycle.
- flush  in  1  synchronous kill of the held and incoming result.
- result  out  WIDTH  registered result.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts result.
- err  out  1  registered error flag, qualified by out_valid.

## Operation
- **Accept:** a transfer occurs when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational, no bubble on back-to-back transfers).
- **Non-load select:** if sel < NUM_SRC and sel != LOAD_SRC, the captured result is src_data[sel], unmodified.
- **Load select:** if sel == LOAD_SRC, take word w = source[31:0] and lane = w >> (8*addr_lo).
  - LB / LBU: lane[7:0], sign-/zero-extended to WIDTH.
  - LH / LHU: lane[15:0], sign-/zero-extended to WIDTH.
  - LW: w, sign-extended to WIDTH.
- **Misaligned load:** LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0. Result = 0, err = 1.
- **Illegal funct3 on a load:** 011, 110, 111. Result = 0, err = 1.
- **Out-of-range select:** sel ≥ NUM_SRC (possible when NUM_SRC is not a power of 2). Result = 0, err = 1.
- **err** is 0 for every legal transfer. The result register is never X.
- **Hold:** when out_valid && !out_ready, result and err are held stable. Inputs are ignored, and in_ready = 0.
- **Flush:** out_valid is cleared next cycle. Any same-cycle transfer is discarded, although in_ready is still computed as above. result and err keep their previous values.
- **Reset:** out_valid = 0, result = 0, err = 0.

## Timing
- Latency: 1 cycle from the accepting edge to out_valid = 1 with result and err valid.
- Throughput: 1 result per cycle while out_ready = 1.
- **Output valid, downstream ready, new input:** the output drains and the new value is captured on the same edge; out_valid stays 1.
- **Output valid, downstream ready, no input:** out_valid = 0 next cycle.
- **Flush with out_ready = 0:** the flush still clears out_valid (flush has priority over hold).
- **Flush with a simultaneous accept:** flush wins; out_valid = 0 next cycle.
- **Reset assertion mid-transfer:** all outputs go to their reset values immediately (asynchronously). The first accept occurs on the first rising edge after reset_n deasserts with in_valid = 1.
- **No combinational paths** from src_data, sel, funct3 or addr_lo to any output. The only combinational output path is out_ready → in_ready.

## Test plan
- **Reset:** reset_n = 0 mid-stream with out_valid = 1 → out_valid = 0, result = 0, err = 0 without waiting for a clock edge; first accept after release yields the correct result one cycle later.
- **Pass-through:** NUM_SRC = 4, sel = 2, src2 = 0xDEADBEEF, out_ready = 1 → next cycle result = 0xDEADBEEF, out_valid = 1, err = 0; back-to-back sel = 0, 3 over consecutive cycles → one result per cycle, in order.
- **Load formatting:** LOAD_SRC word 0x80F0_7F81, with expected results:
  - LB, addr_lo = 0 → 0xFFFFFF81
  - LBU, addr_lo = 3 → 0x00000080
  - LH, addr_lo = 2 → 0xFFFF80F0
  - LHU, addr_lo = 0 → 0x00007F81
  - LW, WIDTH = 64 → 0xFFFFFFFF80F07F81
- **Errors:** each case below → result = 0, err = 1:
  - LW with addr_lo = 2
  - LH with addr_lo = 1
  - funct3 = 011
  - NUM_SRC = 3 with sel = 3

  A following legal transfer → err = 0.
- **Backpressure:** out_ready = 0 for 3 cycles with in_valid = 1 → result held, in_ready = 0, no input lost; out_ready = 1 → drain and capture on the same edge.
- **Flush:** flush with out_ready = 0 and in_valid = 1 → out_valid = 0 next cycle, and the incoming value never appears on the output.

Source files
------------

// File: rtl/wb_result_stage_if.sv
// Writeback result stage bus: upstream source/select/handshake and downstream result/handshake.
// The master side drives sources and out_ready; the slave side is the result stage.
interface wb_result_stage_if #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 4
);
   localparam int SEL_W = $clog2(NUM_SRC);

   logic [NUM_SRC*WIDTH-1:0] src_data;
   logic [SEL_W-1:0]         sel;
   logic [2:0]               funct3;
   logic [1:0]               addr_lo;
   logic                     in_valid;
   logic                     in_ready;
   logic                     flush;
   logic [WIDTH-1:0]         result;
   logic                     out_valid;
   logic                     out_ready;
   logic                     err;

   modport master (
      output src_data, sel, funct3, addr_lo, in_valid, flush, out_ready,
      input  in_ready, result, out_valid, err
   );

   modport slave (
      input  src_data, sel, funct3, addr_lo, in_valid, flush, out_ready,
      output in_ready, result, out_valid, err
   );
endinterface

// File: rtl/wb_result_stage.sv
// Registered writeback result selector: picks one of NUM_SRC sources, formats load data,
// and holds the result in a one-entry valid/ready pipeline register with flush and error flag.
module wb_result_stage #(
   parameter int  WIDTH    = 32,
   parameter int  NUM_SRC  = 4,
   parameter int  LOAD_SRC = 1,
   localparam int SEL_W    = $clog2(NUM_SRC)
) (
   input logic               clk,
   input logic               reset_n,
   wb_result_stage_if.slave  bus
);
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic [WIDTH-1:0] w_sel_data;
   logic             w_in_range;
   logic             w_is_load;
   logic [31:0]      w_word;
   logic [15:0]      w_lane;
   logic [WIDTH-1:0] w_load_res;
   logic             w_load_err;
   logic [WIDTH-1:0] w_next_res;
   logic             w_next_err;
   logic             w_in_ready;
   logic             w_accept;

   logic [WIDTH-1:0] r_result;
   logic             r_err;
   logic             r_valid;

   // Any select value not matched here is out of range (only reachable when NUM_SRC is not 2^n).
   always_comb begin
      w_sel_data = '0;
      w_in_range = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.sel == SEL_W'(i)) begin
            w_sel_data = bus.src_data[i*WIDTH +: WIDTH];
            w_in_range = 1'b1;
         end
      end
   end

   assign w_is_load = (bus.sel == SEL_W'(LOAD_SRC));
   assign w_word    = w_sel_data[31:0];
   assign w_lane    = 16'(w_word >> {bus.addr_lo, 3'b000});

   always_comb begin
      w_load_res = '0;
      w_load_err = 1'b0;
      case (bus.funct3)
         F3_LB:  w_load_res = WIDTH'($signed(w_lane[7:0]));
         F3_LBU: w_load_res = WIDTH'(w_lane[7:0]);
         F3_LH: begin
            if (bus.addr_lo[0]) w_load_err = 1'b1;
            else                w_load_res = WIDTH'($signed(w_lane));
         end
         F3_LHU: begin
            if (bus.addr_lo[0]) w_load_err = 1'b1;
            else                w_load_res = WIDTH'(w_lane);
         end
         F3_LW: begin
            if (bus.addr_lo != 2'b00) w_load_err = 1'b1;
            else                      w_load_res = WIDTH'($signed(w_word));
         end
         default: w_load_err = 1'b1;
      endcase
   end

   // Error cases force a zero result so the register never carries partial load data.
   always_comb begin
      w_next_res = '0;
      w_next_err = 1'b0;
      if (!w_in_range) begin
         w_next_err = 1'b1;
      end else if (w_is_load) begin
         w_next_err = w_load_err;
         w_next_res = w_load_err ? '0 : w_load_res;
      end else begin
         w_next_res = w_sel_data;
      end
   end

   assign w_in_ready = !r_valid || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready;

   // Flush beats both hold and accept; result/err keep their last value across a flush.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid  <= 1'b0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         if (bus.flush)       r_valid <= 1'b0;
         else if (w_in_ready) r_valid <= bus.in_valid;
         if (w_accept && !bus.flush) begin
            r_result <= w_next_res;
            r_err    <= w_next_err;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.result    = r_result;
   assign bus.out_valid = r_valid;
   assign bus.err       = r_err;
endmodule
